// File: rtl/eprobe_pkg.sv
// eprobe_pkg
// Shared definitions for the E-probe command path: command field positions,
// method codes, scheduler FSM state encoding and a small decode helper.
// Command format: [15:14 method | 13:11 VLED | 10 EN | 9:0 LEDADDR]
package eprobe_pkg;

  localparam int CMD_W_DEF = 16;

  localparam int METH_HI = 15;
  localparam int METH_LO = 14;
  localparam int VLED_HI = 13;
  localparam int VLED_LO = 11;
  localparam int EN_BIT  = 10;
  localparam int ADDR_HI = 9;
  localparam int ADDR_LO = 0;

  localparam logic [1:0] METH_NOP     = 2'b00;
  localparam logic [1:0] METH_PIX     = 2'b01;
  localparam logic [1:0] METH_ALL     = 2'b10;
  localparam logic [1:0] METH_ALL_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DWELL = 2'd2
  } sched_state_e;

  // NOP commands are consumed by the scheduler and never reach the LED FSM.
  function automatic logic is_nop(input logic [1:0] meth);
    return (meth == METH_NOP);
  endfunction

endpackage

// File: rtl/eprobe_rr_arb2.sv
// eprobe_rr_arb2
// Two-requester round-robin arbiter. When both requests are high the
// requester that was not accepted last wins; a lone request always wins.
// The priority pointer only moves when the caller signals an acceptance.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer favours req[0])
//   req[1:0]  : request vector (bit0 host, bit1 scan)
//   advance   : the currently selected request was accepted this cycle
//   sel[1:0]  : one-hot selection (zero when no request)
module eprobe_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] sel
);
  import eprobe_pkg::*;

  logic prio_scan;

  always_comb begin
    sel = 2'b00;
    if (req == 2'b11) begin
      sel = prio_scan ? 2'b10 : 2'b01;
    end else begin
      sel = req;
    end
  end

  // After accepting host, scan gets priority next time, and vice versa.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_scan <= 1'b0;
    end else if (advance) begin
      prio_scan <= sel[0];
    end
  end

endmodule

// File: rtl/eprobe_cmd_scheduler.sv
// eprobe_cmd_scheduler
// Arbitrates LED commands from the host pipe and the autoscan sequencer and
// issues them one at a time to the LED controller over valid/ready. NOP
// commands are swallowed. With EPROBE_SCHED_DWELL_EN defined, a programmable
// idle time follows each issued command so the LED DAC can settle; without
// it the dwell input is ignored.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   host_cmd/valid/ready         : requester 0
//   scan_cmd/valid/ready         : requester 1
//   dwell                        : idle cycles after each issue, sampled at handshake
//   out_cmd/out_valid/out_ready  : downstream command channel
//   grant                        : one-hot owner of command in flight
//   busy                         : FSM not idle
//   issue_cnt                    : issued command count (wraps)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepting; ready driven to the round-robin winner
// ST_ISSUE | out_valid high, out_cmd/grant frozen until out_ready
// ST_DWELL | settling delay after an issue (EPROBE_SCHED_DWELL_EN only)
module eprobe_cmd_scheduler #(
  parameter int CMD_W   = 16,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CMD_W-1:0]   host_cmd,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [CMD_W-1:0]   scan_cmd,
  input  logic               scan_valid,
  output logic               scan_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [CMD_W-1:0]   out_cmd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         grant,
  output logic               busy,
  output logic [15:0]        issue_cnt
);
  import eprobe_pkg::*;

  sched_state_e state, state_nxt;

  logic [1:0]       sel;
  logic             idle_ok;
  logic             accept;
  logic [CMD_W-1:0] acc_cmd;
  logic             acc_nop;
  logic             load_cmd;
  logic             issue_done;

  // Ready is forced low during reset so no command is consumed while the
  // scheduler is being cleared.
  assign idle_ok    = (state == ST_IDLE) && !rst;
  assign host_ready = sel[0] & idle_ok;
  assign scan_ready = sel[1] & idle_ok;
  assign accept     = (host_valid & host_ready) | (scan_valid & scan_ready);
  assign acc_cmd    = sel[1] ? scan_cmd : host_cmd;
  assign acc_nop    = is_nop(acc_cmd[CMD_W-1 -: 2]);

  assign out_valid  = (state == ST_ISSUE);
  assign busy       = (state != ST_IDLE);
  assign issue_done = out_valid & out_ready;

  eprobe_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({scan_valid, host_valid}),
    .advance (accept),
    .sel     (sel)
  );

`ifdef EPROBE_SCHED_DWELL_EN
  logic [DWELL_W-1:0] dwell_cnt;
`else
  logic dwell_unused;
  assign dwell_unused = ^dwell;
`endif

  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && !acc_nop) begin
          load_cmd  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (out_ready) begin
`ifdef EPROBE_SCHED_DWELL_EN
          state_nxt = (dwell == '0) ? ST_IDLE : ST_DWELL;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef EPROBE_SCHED_DWELL_EN
      ST_DWELL: begin
        // Leaving when the count is 1 makes the idle gap exactly dwell cycles.
        if (dwell_cnt <= DWELL_W'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_cmd   <= '0;
      grant     <= 2'b00;
      issue_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (load_cmd) begin
        out_cmd <= acc_cmd;
        grant   <= sel;
      end else if (state != ST_IDLE && state_nxt == ST_IDLE) begin
        grant <= 2'b00;
      end
      if (issue_done) begin
        issue_cnt <= issue_cnt + 16'd1;
      end
    end
  end

`ifdef EPROBE_SCHED_DWELL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
    end else if (issue_done) begin
      dwell_cnt <= dwell;
    end else if (state == ST_DWELL) begin
      dwell_cnt <= dwell_cnt - DWELL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_eprobe_cmd_scheduler.sv
// Randomized scoreboard bench for eprobe_cmd_scheduler. A reference model
// tracks who should be ready each cycle, pushes expected issues into a queue,
// and a monitor pops and compares on each downstream handshake.
module tb_eprobe_cmd_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] host_cmd = 16'd0, scan_cmd = 16'd0;
  logic        host_valid = 1'b0, scan_valid = 1'b0;
  logic        host_ready, scan_ready;
  logic [23:0] dwell = 24'd0;
  logic [15:0] out_cmd;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] issue_cnt;

  eprobe_cmd_scheduler #(.CMD_W(16), .DWELL_W(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .scan_cmd   (scan_cmd),
    .scan_valid (scan_valid),
    .scan_ready (scan_ready),
    .dwell      (dwell),
    .out_cmd    (out_cmd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant      (grant),
    .busy       (busy),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  event smp;
  always @(negedge clk) begin
    #3;
    ->smp;
  end

  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // stimulus state
  logic [15:0] host_q[$];
  logic [15:0] scan_q[$];
  int  vprob = 100;
  int  rdy_mode = 0;
  bit  dwell_rand = 0;
  bit  h_acc = 0, s_acc = 0;
  bit  chk_en = 0;

  always @(negedge clk) begin
    if (h_acc) host_valid = 1'b0;
    if (s_acc) scan_valid = 1'b0;
    if (!host_valid && host_q.size() > 0 && $urandom_range(1, 100) <= vprob) begin
      host_cmd   = host_q.pop_front();
      host_valid = 1'b1;
    end
    if (!scan_valid && scan_q.size() > 0 && $urandom_range(1, 100) <= vprob) begin
      scan_cmd   = scan_q.pop_front();
      scan_valid = 1'b1;
    end
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (dwell_rand && $urandom_range(0, 9) == 0) dwell = 24'($urandom_range(0, 7));
  end

  // reference model: {expected issue_cnt at handshake, grant, cmd}
  logic [33:0] exp_q[$];
  bit          in_flight = 0;
  int          acc_cyc = 0;
  int          free_at = 0;
  bit          prio_scan = 0;
  logic [15:0] exp_cnt = 16'd0;

  function automatic int dwell_eff();
`ifdef EPROBE_SCHED_DWELL_EN
    return int'(dwell);
`else
    return 0;
`endif
  endfunction

  always @(smp) begin : model
    logic [1:0]  vld, er;
    logic [15:0] c;
    bit          mv, idle;
    if (chk_en) begin
      mv = in_flight && (cyc > acc_cyc);
      chk("out_valid", out_valid, mv);
      chk("busy", busy, mv || (cyc < free_at));
      if (!(mv || (cyc < free_at))) chk("grant_idle", grant, 2'b00);
      idle = !in_flight && (cyc >= free_at);
      vld  = {scan_valid, host_valid};
      er   = 2'b00;
      if (!rst && idle) er = (vld == 2'b11) ? (prio_scan ? 2'b10 : 2'b01) : vld;
      chk("ready", {scan_ready, host_ready}, er);
      h_acc = host_valid && host_ready;
      s_acc = scan_valid && scan_ready;
      if (rst) begin
        in_flight = 0;
        free_at   = 0;
        prio_scan = 0;
        exp_cnt   = 16'd0;
        exp_q.delete();
      end else begin
        if (mv && out_ready) begin
          in_flight = 0;
          exp_cnt   = exp_cnt + 16'd1;
          free_at   = cyc + 1 + dwell_eff();
        end
        if (er != 2'b00) begin
          c = er[1] ? scan_cmd : host_cmd;
          prio_scan = er[0];
          if (c[15:14] != 2'b00) begin
            exp_q.push_back({exp_cnt, er, c});
            in_flight = 1;
            acc_cyc   = cyc;
          end
        end
      end
    end
  end

  logic [1:0] grant_log[$];

  always @(smp) begin : monitor
    logic [33:0] e;
    if (chk_en && !rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_valid_unexpected", out_valid, 1'b0);
      end else begin
        e = exp_q[0];
        chk("out_cmd", out_cmd, e[15:0]);
        chk("grant", grant, e[17:16]);
        if (out_ready) begin
          chk("issue_cnt", issue_cnt, e[33:18]);
          grant_log.push_back(grant);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(smp);
      if (host_q.size() == 0 && scan_q.size() == 0 && !host_valid && !scan_valid && !busy) break;
    end
    if (i >= budget) chk("drain_timeout", {host_valid, scan_valid, busy}, 3'b000);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    rst = 1'b0;
    @(smp);
    chk("rst_out_cmd", out_cmd, 16'h0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_issue_cnt", issue_cnt, 16'h0000);

    // host-only single command
    host_q.push_back(16'h4C05);
    wait_idle(100);
    chk("host_only_cnt", issue_cnt, 16'd1);
    chk("host_only_cmd", out_cmd, 16'h4C05);

    // alternation from a fresh reset: host, scan, host, scan ...
    pulse_rst();
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      host_q.push_back(16'h4000 | 16'(i));
      scan_q.push_back(16'h8100 | 16'(i));
    end
    wait_idle(200);
    chk("alt_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      chk("alt_grant", grant_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // NOP from scan is swallowed; host then has priority
    scan_q.push_back(16'h0123);
    wait_idle(100);
    chk("nop_cnt", issue_cnt, 16'd8);
    host_q.push_back(16'h4222);
    scan_q.push_back(16'h4111);
    wait_idle(100);
    chk("after_nop_cnt", issue_cnt, 16'd10);

    // fixed dwell between back-to-back host commands
    dwell = 24'd5;
    host_q.push_back(16'h4333);
    host_q.push_back(16'h4444);
    wait_idle(200);
    dwell = 24'd0;

    // stalled issue, then reset drops it
    rdy_mode = 2;
    host_q.push_back(16'h8ABC);
    for (int i = 0; i < 50 && !out_valid; i++) @(smp);
    chk("stall_out_valid", out_valid, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(smp);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_issue_cnt", issue_cnt, 16'd0);
    chk("midrst_out_cmd", out_cmd, 16'd0);
    rdy_mode = 0;

    // randomized traffic
    rdy_mode   = 1;
    dwell_rand = 1;
    vprob      = 50;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0 && host_q.size() < 4) host_q.push_back(16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 3) == 0 && scan_q.size() < 4) scan_q.push_back(16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      else rst = 1'b0;
    end
    @(negedge clk);
    rst      = 1'b0;
    rdy_mode = 0;
    wait_idle(500);
    chk("leftover_expected", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
